// File: rtl/stream_demux_1n.sv
`default_nettype none
// ============================================================================
// Module : stream_demux_1n
// Registered 1-to-N valid/ready stream demultiplexer with packet lock and a
// saturating counter of beats discarded for out-of-range destinations.
// Rev    : 1.0  initial release
// ============================================================================
module stream_demux_1n #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_last,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [0:0]     c_IDLE = 1'b0;
  localparam logic [0:0]     c_LOCK = 1'b1;
  localparam logic [SEL_W:0] c_N_CH = (SEL_W+1)'(N_CH);

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_locked_sel;
  logic [CNT_W-1:0] r_drop;

  logic [SEL_W-1:0] w_tgt;
  logic             w_tgt_ok;
  logic [N_CH-1:0]  w_free;
  logic             w_acc;

  assign w_tgt    = (r_state == c_LOCK) ? r_locked_sel : in_sel;
  assign w_tgt_ok = ({1'b0, w_tgt} < c_N_CH);
  // Out-of-range targets act as an always-ready sink so the packet drains.
  assign in_ready = rst_n && (w_tgt_ok ? w_free[w_tgt] : 1'b1);
  assign w_acc    = in_valid && in_ready;
  assign drop_cnt = r_drop;

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_ch
      logic              w_wr;
      logic              r_vld;
      logic              r_lst;
      logic [DATA_W-1:0] r_dat;

      assign w_wr = w_acc && w_tgt_ok && (w_tgt == SEL_W'(k));
      // A draining slot counts as free so a new beat can enter the same cycle.
      assign w_free[k] = !r_vld || out_ready[k];
      assign out_valid[k] = r_vld;
      assign out_last[k]  = r_lst;
      assign out_data[k*DATA_W +: DATA_W] = r_dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_lst <= 1'b0;
          r_dat <= '0;
        end else if (w_wr) begin
          r_vld <= 1'b1;
          r_lst <= in_last;
          r_dat <= in_data;
        end else if (out_ready[k]) begin
          r_vld <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_acc && !w_tgt_ok && (r_drop != {CNT_W{1'b1}})) begin
      r_drop <= r_drop + CNT_W'(1);
    end
  end

  // Destination is captured on the first beat and held until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_locked_sel <= '0;
    end else if (w_acc) begin
      case (r_state)
        c_IDLE: begin
          if (!in_last) begin
            r_state      <= c_LOCK;
            r_locked_sel <= in_sel;
          end
        end
        c_LOCK: begin
          if (in_last) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
